// File: rtl/lock_chamber_ctrl.sv
// Airlock chamber sequencer: flood / outer hatch / drain / inner hatch for arrivals and departures.
// Every output is a flop loaded from the next-state decode, so the hatch interlock holds in every cycle.
module lock_chamber_ctrl #(
  parameter int FILL_CYCLES  = 7,
  parameter int DRAIN_CYCLES = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arriving,
  input  logic             departing,
  input  logic             subIn,
  output logic             outerDoor,
  output logic             innerDoor,
  output logic             filling,
  output logic             draining,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] countdown
);

  typedef enum logic [3:0] {
    IDLE, A_FILL, A_OUTER, A_DRAIN, A_INNER,
    D_INNER, D_FILL, D_OUTER, D_DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] FILL_N  = CNT_W'(FILL_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_N = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             expire;

  // The phase ends on the edge that would take the count below 1.
  assign expire = (cnt <= ONE);

  always_comb begin
    nxt      = state;
    cnt_nxt  = '0;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (arriving) begin
          nxt     = A_FILL;
          cnt_nxt = FILL_N;
        end else if (departing) begin
          nxt = D_INNER;
        end
      end
      A_FILL: begin
        if (expire) nxt = A_OUTER;
        else        cnt_nxt = cnt - ONE;
      end
      A_OUTER: begin
        if (subIn) begin
          nxt     = A_DRAIN;
          cnt_nxt = DRAIN_N;
        end
      end
      A_DRAIN: begin
        if (expire) nxt = A_INNER;
        else        cnt_nxt = cnt - ONE;
      end
      A_INNER: begin
        if (!subIn) begin
          nxt      = IDLE;
          done_nxt = 1'b1;
        end
      end
      D_INNER: begin
        if (subIn) begin
          nxt     = D_FILL;
          cnt_nxt = FILL_N;
        end
      end
      D_FILL: begin
        if (expire) nxt = D_OUTER;
        else        cnt_nxt = cnt - ONE;
      end
      D_OUTER: begin
        if (!subIn) begin
          nxt     = D_DRAIN;
          cnt_nxt = DRAIN_N;
        end
      end
      D_DRAIN: begin
        if (expire) begin
          nxt      = IDLE;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      outerDoor <= 1'b0;
      innerDoor <= 1'b0;
      filling   <= 1'b0;
      draining  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      outerDoor <= (nxt == A_OUTER) || (nxt == D_OUTER);
      innerDoor <= (nxt == A_INNER) || (nxt == D_INNER);
      filling   <= (nxt == A_FILL)  || (nxt == D_FILL);
      draining  <= (nxt == A_DRAIN) || (nxt == D_DRAIN);
      busy      <= (nxt != IDLE);
      done      <= done_nxt;
    end
  end

  // cnt is cleared on every edge that leaves or bypasses a fill/drain phase.
  assign countdown = cnt;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Bench for lock_chamber_ctrl: default instance plus a FILL=1/DRAIN=15 instance,
// table-driven sequences with a queued expected-output scoreboard and random interlock checks.
module tb_lock_chamber_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a [2];
  logic       d [2];
  logic       s [2];
  logic [1:0] od, idr, fl, dr, bs, dn;
  logic [3:0] cd [2];

  lock_chamber_ctrl u0 (
    .clk(clk), .reset(reset), .arriving(a[0]), .departing(d[0]), .subIn(s[0]),
    .outerDoor(od[0]), .innerDoor(idr[0]), .filling(fl[0]), .draining(dr[0]),
    .busy(bs[0]), .done(dn[0]), .countdown(cd[0])
  );

  lock_chamber_ctrl #(.FILL_CYCLES(1), .DRAIN_CYCLES(15), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .arriving(a[1]), .departing(d[1]), .subIn(s[1]),
    .outerDoor(od[1]), .innerDoor(idr[1]), .filling(fl[1]), .draining(dr[1]),
    .busy(bs[1]), .done(dn[1]), .countdown(cd[1])
  );

  typedef struct packed {
    logic       o, i, f, dr, b, dn;
    logic [3:0] c;
  } out_t;

  typedef struct {
    int    k;
    logic  a, d, s;
    out_t  exp;
    string nm;
  } vec_t;

  vec_t tbl [$];
  out_t sbq [$];
  int   checks   = 0;
  int   failures = 0;

  function automatic out_t eo(logic o, logic i, logic f, logic r, logic b, logic n, int c);
    out_t e;
    e.o = o; e.i = i; e.f = f; e.dr = r; e.b = b; e.dn = n; e.c = 4'(c);
    return e;
  endfunction

  function automatic out_t e_idle();       return eo(0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic out_t e_done();       return eo(0, 0, 0, 0, 0, 1, 0); endfunction
  function automatic out_t e_outer();      return eo(1, 0, 0, 0, 1, 0, 0); endfunction
  function automatic out_t e_inner();      return eo(0, 1, 0, 0, 1, 0, 0); endfunction
  function automatic out_t e_fill(int n);  return eo(0, 0, 1, 0, 1, 0, n); endfunction
  function automatic out_t e_drain(int n); return eo(0, 0, 0, 1, 1, 0, n); endfunction

  function automatic out_t act(int k);
    out_t g;
    g.o = od[k]; g.i = idr[k]; g.f = fl[k]; g.dr = dr[k];
    g.b = bs[k]; g.dn = dn[k]; g.c = cd[k];
    return g;
  endfunction

  task automatic chk(string nm, out_t got, out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got={o%b i%b f%b d%b b%b dn%b c%0d} exp={o%b i%b f%b d%b b%b dn%b c%0d}",
               nm, got.o, got.i, got.f, got.dr, got.b, got.dn, got.c,
               exp.o, exp.i, exp.f, exp.dr, exp.b, exp.dn, exp.c);
    end
  endtask

  // Drive, queue the expectation, then compare after the edge that consumes the inputs.
  task automatic step(int k, logic a_, logic d_, logic s_, out_t e, string nm);
    a[k] = a_; d[k] = d_; s[k] = s_;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    chk(nm, act(k), sbq.pop_front());
  endtask

  task automatic add(int k, logic a_, logic d_, logic s_, out_t e, string nm);
    vec_t v;
    v.k = k; v.a = a_; v.d = d_; v.s = s_; v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    // Arrival with default timing; subIn toggles during drain must be ignored.
    add(0, 1, 0, 0, e_fill(7), "arr_fill");
    for (int n = 6; n >= 1; n--) add(0, 0, 0, 0, e_fill(n), "arr_fill");
    add(0, 0, 0, 0, e_outer(), "arr_outer");
    add(0, 0, 0, 0, e_outer(), "arr_outer_hold");
    add(0, 0, 0, 1, e_drain(8), "arr_drain");
    for (int n = 7; n >= 1; n--) add(0, 0, 0, logic'(n % 2), e_drain(n), "arr_drain");
    add(0, 0, 0, 1, e_inner(), "arr_inner");
    add(0, 0, 0, 1, e_inner(), "arr_inner_hold");
    add(0, 0, 0, 0, e_done(), "arr_done");
    add(0, 0, 0, 0, e_idle(), "arr_idle");
    // Departure.
    add(0, 0, 1, 0, e_inner(), "dep_inner");
    add(0, 0, 0, 0, e_inner(), "dep_inner_hold");
    add(0, 0, 0, 1, e_fill(7), "dep_fill");
    for (int n = 6; n >= 1; n--) add(0, 0, 0, 1, e_fill(n), "dep_fill");
    add(0, 0, 0, 1, e_outer(), "dep_outer");
    add(0, 0, 0, 1, e_outer(), "dep_outer_hold");
    add(0, 0, 0, 0, e_drain(8), "dep_drain");
    for (int n = 7; n >= 1; n--) add(0, 0, 0, 0, e_drain(n), "dep_drain");
    add(0, 0, 0, 0, e_done(), "dep_done");
    add(0, 0, 0, 0, e_idle(), "dep_idle");
    // Simultaneous request: arrival wins; departing toggles mid-sequence, then held for back-to-back.
    add(0, 1, 1, 0, e_fill(7), "sim_fill");
    for (int n = 6; n >= 1; n--) add(0, 0, logic'(n % 2), 0, e_fill(n), "sim_fill");
    add(0, 0, 1, 0, e_outer(), "sim_outer");
    add(0, 0, 1, 1, e_drain(8), "sim_drain");
    for (int n = 7; n >= 1; n--) add(0, 0, logic'(n % 2), 1, e_drain(n), "sim_drain");
    add(0, 0, 1, 1, e_inner(), "sim_inner");
    add(0, 0, 1, 0, e_done(), "b2b_done");
    add(0, 0, 1, 0, e_inner(), "b2b_dep_inner");
    add(0, 0, 0, 1, e_fill(7), "b2b_fill");
    for (int n = 6; n >= 1; n--) add(0, 0, 0, 1, e_fill(n), "b2b_fill");
    add(0, 0, 0, 1, e_outer(), "b2b_outer");
    add(0, 0, 0, 0, e_drain(8), "b2b_drain");
    for (int n = 7; n >= 1; n--) add(0, 0, 0, 0, e_drain(n), "b2b_drain");
    add(0, 0, 0, 0, e_done(), "b2b_done2");
    add(0, 0, 0, 0, e_idle(), "b2b_idle");
    // Alternate parameters: single fill cycle, fifteen drain cycles.
    add(1, 1, 0, 0, e_fill(1), "par_fill");
    add(1, 0, 0, 0, e_outer(), "par_outer");
    add(1, 0, 0, 1, e_drain(15), "par_drain");
    for (int n = 14; n >= 1; n--) add(1, 0, 0, 1, e_drain(n), "par_drain");
    add(1, 0, 0, 1, e_inner(), "par_inner");
    add(1, 0, 0, 0, e_done(), "par_done");
    add(1, 0, 0, 0, e_idle(), "par_idle");

    // Reset state and mid-sequence abort.
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin a[k] = 0; d[k] = 0; s[k] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state0", act(0), e_idle());
    chk("rst_state1", act(1), e_idle());
    reset = 1'b1;
    step(0, 1, 0, 0, e_fill(7), "rst_fill");
    for (int n = 6; n >= 1; n--) step(0, 0, 0, 0, e_fill(n), "rst_fill");
    step(0, 0, 0, 0, e_outer(), "rst_outer");
    reset = 1'b0;
    #1;
    chk("rst_abort", act(0), e_idle());
    @(posedge clk);
    #1;
    chk("rst_hold", act(0), e_idle());
    reset = 1'b1;
    step(0, 0, 0, 0, e_idle(), "rst_release");

    foreach (tbl[i]) step(tbl[i].k, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].exp, tbl[i].nm);

    // Random interlock soak.
    for (int c = 0; c < 10000; c++) begin
      a[0] = ($urandom_range(0, 7) == 0);
      d[0] = ($urandom_range(0, 5) == 0);
      s[0] = ($urandom_range(0, 3) != 0) ? s[0] : ~s[0];
      @(posedge clk);
      #1;
      checks++;
      if (od[0] && idr[0]) begin
        failures++;
        $display("FAIL interlock_doors cycle=%0d outer=%b inner=%b required not both", c, od[0], idr[0]);
      end
      checks++;
      if ((od[0] || idr[0]) && (fl[0] || dr[0])) begin
        failures++;
        $display("FAIL interlock_water cycle=%0d doors=%b%b fill=%b drain=%b required no door while water moves",
                 c, od[0], idr[0], fl[0], dr[0]);
      end
      checks++;
      if (!(fl[0] || dr[0]) && (cd[0] != 4'd0)) begin
        failures++;
        $display("FAIL countdown_idle cycle=%0d got=%0d required=0", c, cd[0]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
